// File: rtl/div_seq_pkg.sv
// div_seq_pkg: shared state encoding and constants for the iterative divider
package div_seq_pkg;
  localparam int WIDTH_DEF = 32;
  localparam logic [WIDTH_DEF-1:0] DBZ_QUO = '1;
  typedef enum logic [2:0] {IDLE, PREP, RUN, FIXUP, DONE} state_t;
endpackage

// File: rtl/div_step.sv
// div_step: one combinational restoring shift-subtract iteration
module div_step
  import div_seq_pkg::*;
#(
  parameter int WIDTH = WIDTH_DEF
) (
  input  logic [WIDTH-1:0] i_rem,
  input  logic [WIDTH-1:0] i_quo,
  input  logic [WIDTH-1:0] i_divisor,
  output logic [WIDTH-1:0] o_rem,
  output logic [WIDTH-1:0] o_quo
);
  logic [WIDTH:0] w_sh;
  logic           w_ge;
  assign w_sh  = {i_rem, i_quo[WIDTH-1]};
  assign w_ge  = w_sh >= {1'b0, i_divisor};
  assign o_rem = w_ge ? WIDTH'(w_sh - {1'b0, i_divisor}) : w_sh[WIDTH-1:0];
  assign o_quo = {i_quo[WIDTH-2:0], w_ge};
endmodule

// File: rtl/div_sequencer.sv
// div_sequencer: multi-cycle DIV/DIVU controller with stall, abort and sign fix-up
module div_sequencer
  import div_seq_pkg::*;
#(
  parameter int WIDTH = WIDTH_DEF,
  parameter int CNT_W = 6
) (
  input  logic             clock,
  input  logic             reset_n,
  input  logic             start_e,
  input  logic             is_signed_e,
  input  logic [WIDTH-1:0] dividend_e,
  input  logic [WIDTH-1:0] divisor_e,
  input  logic             abort,
  output logic             div_stall,
  output logic             busy,
  output logic             result_valid,
  output logic [WIDTH-1:0] div_hi,
  output logic [WIDTH-1:0] div_lo,
  output logic             div_by_zero
);
  state_t           r_state, w_next;
  logic [CNT_W-1:0] r_cnt;
  logic [WIDTH-1:0] r_dvd, r_dvs, r_rem, r_quo, r_hi, r_lo;
  logic [WIDTH-1:0] w_rem, w_quo, w_dvd_abs, w_dvs_abs;
  logic             r_signed, r_neg_q, r_neg_r, r_dbz, w_accept;

  assign w_accept     = r_state == IDLE && start_e && !abort;
  assign w_dvd_abs    = r_signed && r_dvd[WIDTH-1] ? -r_dvd : r_dvd;
  assign w_dvs_abs    = r_signed && r_dvs[WIDTH-1] ? -r_dvs : r_dvs;
  assign busy         = r_state != IDLE;
  assign div_stall    = reset_n && (w_accept || r_state inside {PREP, RUN, FIXUP});
  assign result_valid = r_state == DONE && !abort;
  assign div_hi       = r_hi;
  assign div_lo       = r_lo;
  assign div_by_zero  = r_dbz;

  div_step #(.WIDTH(WIDTH)) u_step (
    .i_rem    (r_rem),
    .i_quo    (r_quo),
    .i_divisor(r_dvs),
    .o_rem    (w_rem),
    .o_quo    (w_quo)
  );

  // state register
  always_ff @(posedge clock or negedge reset_n)
    if (!reset_n) r_state <= IDLE;
    else          r_state <= w_next;

  // next-state: abort wins from any busy state, divide-by-zero skips the iterations
  always_comb begin
    w_next = IDLE;
    if (!(busy && abort))
      case (r_state)
        IDLE:    w_next = w_accept ? PREP : IDLE;
        PREP:    w_next = r_dvs == '0 ? DONE : RUN;
        RUN:     w_next = r_cnt == CNT_W'(1) ? FIXUP : RUN;
        FIXUP:   w_next = DONE;
        default: w_next = IDLE;
      endcase
  end

  // operand capture, iteration datapath and result registers
  always_ff @(posedge clock or negedge reset_n)
    if (!reset_n) begin
      r_cnt    <= '0;
      r_dvd    <= '0;
      r_dvs    <= '0;
      r_rem    <= '0;
      r_quo    <= '0;
      r_hi     <= '0;
      r_lo     <= '0;
      r_signed <= 1'b0;
      r_neg_q  <= 1'b0;
      r_neg_r  <= 1'b0;
      r_dbz    <= 1'b0;
    end else begin
      if (w_accept) begin
        r_dvd    <= dividend_e;
        r_dvs    <= divisor_e;
        r_signed <= is_signed_e;
        r_neg_q  <= is_signed_e && (dividend_e[WIDTH-1] ^ divisor_e[WIDTH-1]);
        r_neg_r  <= is_signed_e && dividend_e[WIDTH-1];
        r_dbz    <= 1'b0;
      end
      if (r_state == PREP && !abort) begin
        if (r_dvs == '0) begin
          r_dbz <= 1'b1;
          r_lo  <= DBZ_QUO;
          r_hi  <= r_dvd;
        end else begin
          r_cnt <= CNT_W'(WIDTH);
          r_rem <= '0;
          r_quo <= w_dvd_abs;
          r_dvs <= w_dvs_abs;
        end
      end
      if (r_state == RUN && !abort) begin
        r_rem <= w_rem;
        r_quo <= w_quo;
        r_cnt <= r_cnt - CNT_W'(1);
      end
      if (r_state == FIXUP && !abort) begin
        r_lo <= r_neg_q ? -r_quo : r_quo;
        r_hi <= r_neg_r ? -r_rem : r_rem;
      end
    end
endmodule

// File: doc/div_sequencer.md
Name: div_sequencer

Overview:
- Multi-cycle iterative divider controller for the EX stage. It replaces single-cycle DIV/DIVU evaluation.
- Accepts a divide request from the EX stage and sequences a restoring shift-subtract datapath, one quotient bit per cycle.
- Raises a stall to the hazard unit while busy. Presents HI/LO results that travel with the instruction into the memory stage, then into the writeback HI/LO write.

Parameters:
- WIDTH, 32, operand/result width in bits.
- CNT_W, 6, iteration counter width; must satisfy 2^CNT_W > WIDTH.

Ports:
- clock  in  1  rising-edge clock.
- reset_n  in  1  asynchronous active-low reset.
- start_e  in  1  DIV/DIVU instruction present in EX (HasDivE-qualified, not flushed).
- is_signed_e  in  1  1=DIV, 0=DIVU.
- dividend_e  in  WIDTH  forwarded rs value.
- divisor_e  in  WIDTH  forwarded rt value.
- abort  in  1  kill in-flight operation (exception/redirect).
- div_stall  out  1  hold F/D/E stages; to hazard unit.
- busy  out  1  state != IDLE.
- result_valid  out  1  one-cycle pulse; div_hi/div_lo valid.
- div_hi  out  WIDTH  remainder.
- div_lo  out  WIDTH  quotient.
- div_by_zero  out  1  sticky per-op flag; set when divisor was 0.

Behaviour:
- States: IDLE, PREP, RUN, FIXUP, DONE.
- Reset (async, reset_n=0): state=IDLE; counter=0; div_hi=0; div_lo=0; div_by_zero=0; result_valid=0; div_stall=0.
- IDLE, start_e=1, abort=0:
  - Latch operands, signedness, and result signs (quotient negative = signs differ & signed; remainder negative = dividend sign & signed).
  - Go to PREP. Clear div_by_zero.
- PREP:
  - Form magnitudes. Abs of 0x80000000 stays 0x80000000, treated as unsigned.
  - Divisor==0: set div_by_zero; div_lo=all ones; div_hi=raw dividend; go to DONE.
  - Otherwise: counter=WIDTH, partial remainder=0, go to RUN.
- RUN, each cycle:
  - Shift {rem, quo} left by one. Trial subtract divisor from rem.
  - If non-negative, keep the difference and set quo LSB=1; else keep rem and set LSB=0.
  - Decrement counter. Go to FIXUP after the step where counter reaches 0 (exactly WIDTH RUN cycles).
- FIXUP:
  - Apply two's-complement negation per the latched signs. Write div_lo and div_hi. Go to DONE.
  - Signed 0x80000000 / 0xFFFFFFFF naturally yields lo=0x80000000, hi=0; no special case.
- DONE:
  - result_valid=1; div_stall=0 so the instruction advances to M with results on this edge.
  - start_e is ignored (same instruction still present). Next state is IDLE unconditionally.
- div_stall (combinational) = (state==IDLE & start_e & ~abort) | state∈{PREP, RUN, FIXUP}.
- Latency:
  - Normal op: IDLE-accept cycle + PREP + WIDTH RUN + FIXUP = WIDTH+3 stall cycles (35 at WIDTH=32), then DONE.
  - Divide-by-zero: 2 stall cycles, then DONE.
- abort=1 in any non-IDLE state: next state IDLE, no result_valid. div_hi/div_lo keep their prior values. abort has priority over start_e.
- div_hi/div_lo/div_by_zero hold their values between operations until the next FIXUP/PREP write.
- Reset mid-operation: immediate return to reset values; no partial result is visible.

Decomposition:
- Shared package div_seq_pkg holds: the state enum (IDLE, PREP, RUN, FIXUP, DONE), WIDTH default, and the all-ones divide-by-zero quotient constant.
- One sub-module, div_step: purely combinational single restoring iteration. Inputs are rem, quo, divisor; outputs are next rem and next quo.
- The FSM, counter, and sign fix-up stay in div_sequencer.

Test Plan:
- DIVU 100/7, start_e held: div_stall high 35 cycles, result_valid in cycle 35 with div_lo=14, div_hi=2, div_by_zero=0.
- DIV -7/2 (0xFFFFFFF9/2): div_lo=0xFFFFFFFD, div_hi=0xFFFFFFFF. DIV 7/-2: div_lo=0xFFFFFFFD, div_hi=1.
- DIVU 0x12345678/0: result_valid at cycle 2, div_lo=0xFFFFFFFF, div_hi=0x12345678, div_by_zero=1.
- DIV 0x80000000/0xFFFFFFFF: div_lo=0x80000000, div_hi=0. DIVU 0xFFFFFFFF/1: div_lo=0xFFFFFFFF, div_hi=0.
- start_e held through DONE, new DIVU 9/3 start next cycle: exactly one result_valid for the first op, second op accepted from IDLE, yields lo=3, hi=0.
- Checks on the interrupting controls:
  - reset_n low during RUN cycle 10: all outputs 0 asynchronously, state IDLE.
  - abort during RUN: no result_valid, div_stall drops next cycle, prior div_hi/div_lo unchanged.
